// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
//
// Purpose:
//    Two-port arbiter/sequencer in front of the single shared ALU. The fetch
//    path (port 0) and the execute path (port 1) each hand over a complete ALU
//    operation through a valid/ready handshake. One requester is granted at a
//    time. Its operands are registered onto the ALU inputs for one EXEC cycle.
//    The ALU result and flags are then captured and returned to the winner as
//    a one-cycle response pulse. Accept-to-response latency is 2 cycles, and
//    back-to-back operation gives one op every 2 cycles.
//
// Configuration:
//    ALU_ARB_FIXED_PRIO_EN  defined     -> req0 always wins a tie (req1 may starve)
//                           not defined -> round-robin on ties; req0 wins the
//                                          first tie after reset
//
// Ports:
//    clk, rst_n                      clock, asynchronous active-low reset
//    reqN_valid / reqN_ready         request handshake (N = 0,1)
//    reqN_a, reqN_b                  operands
//    reqN_aluop, reqN_funct          ALU op (00 ADD,01 SUB,10 FUNC,11 PASS), function code
//    rspN_valid                      one-cycle response pulse, no backpressure
//    rspN_result, rspN_flags         captured result and {carry, negative, zero}
//    alu_a, alu_b, alu_aluop,
//    alu_funct                       registered controls to the ALU
//    alu_result, alu_zero,
//    alu_negative, alu_carry         ALU outputs
// ---------------------------------------------------------------------------
module alu_share_arb #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [1:0]        req0_aluop,
   input  logic [2:0]        req0_funct,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [1:0]        req1_aluop,
   input  logic [2:0]        req1_funct,

   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_result,
   output logic [2:0]        rsp0_flags,

   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_result,
   output logic [2:0]        rsp1_flags,

   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_aluop,
   output logic [2:0]        alu_funct,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_negative,
   input  logic              alu_carry
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q,       state_d;
   logic                owner_q,       owner_d;
   logic [DATA_W-1:0]   alu_a_q,       alu_a_d;
   logic [DATA_W-1:0]   alu_b_q,       alu_b_d;
   logic [1:0]          alu_aluop_q,   alu_aluop_d;
   logic [2:0]          alu_funct_q,   alu_funct_d;
   logic                rsp0_valid_q,  rsp0_valid_d;
   logic [DATA_W-1:0]   rsp0_result_q, rsp0_result_d;
   logic [2:0]          rsp0_flags_q,  rsp0_flags_d;
   logic                rsp1_valid_q,  rsp1_valid_d;
   logic [DATA_W-1:0]   rsp1_result_q, rsp1_result_d;
   logic [2:0]          rsp1_flags_q,  rsp1_flags_d;

   logic                window;
   logic                pick1;
   logic                accept;

   // ------------------------------------------------------------------------
   // Grant selection. pick1 is true when req1 should be granted; req0 is
   // granted whenever it is valid and req1 is not picked.
   // ------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      pick1 = req1_valid & ~req0_valid;
   end
`else
   logic last_grant_q, last_grant_d;

   // On a tie, serve whichever port was not granted last.
   always_comb begin
      pick1 = req1_valid & (~req0_valid | ~last_grant_q);
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (accept) begin
         last_grant_d = pick1;
      end
   end

   // Resets to 1 so that req0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   // Requests are only taken while the ALU is not busy (IDLE or RESP).
   always_comb begin
      window     = (state_q != EXEC);
      req0_ready = window & req0_valid & ~pick1;
      req1_ready = window & pick1;
      accept     = req0_ready | req1_ready;
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_aluop_d   = alu_aluop_q;
      alu_funct_d   = alu_funct_q;
      rsp0_valid_d  = 1'b0;
      rsp0_result_d = rsp0_result_q;
      rsp0_flags_d  = rsp0_flags_q;
      rsp1_valid_d  = 1'b0;
      rsp1_result_d = rsp1_result_q;
      rsp1_flags_d  = rsp1_flags_q;

      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               owner_d     = pick1;
               alu_a_d     = pick1 ? req1_a     : req0_a;
               alu_b_d     = pick1 ? req1_b     : req0_b;
               alu_aluop_d = pick1 ? req1_aluop : req0_aluop;
               alu_funct_d = pick1 ? req1_funct : req0_funct;
               state_d     = EXEC;
            end else begin
               state_d     = IDLE;
            end
         end
         EXEC: begin
            // ALU inputs have been stable for the whole cycle; capture now.
            if (owner_q) begin
               rsp1_valid_d  = 1'b1;
               rsp1_result_d = alu_result;
               rsp1_flags_d  = {alu_carry, alu_negative, alu_zero};
            end else begin
               rsp0_valid_d  = 1'b1;
               rsp0_result_d = alu_result;
               rsp0_flags_d  = {alu_carry, alu_negative, alu_zero};
            end
            state_d = RESP;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_aluop_q   <= 2'b00;
         alu_funct_q   <= 3'b000;
         rsp0_valid_q  <= 1'b0;
         rsp0_result_q <= '0;
         rsp0_flags_q  <= 3'b000;
         rsp1_valid_q  <= 1'b0;
         rsp1_result_q <= '0;
         rsp1_flags_q  <= 3'b000;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_aluop_q   <= alu_aluop_d;
         alu_funct_q   <= alu_funct_d;
         rsp0_valid_q  <= rsp0_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp0_flags_q  <= rsp0_flags_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp1_result_q <= rsp1_result_d;
         rsp1_flags_q  <= rsp1_flags_d;
      end
   end

   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_aluop   = alu_aluop_q;
   assign alu_funct   = alu_funct_q;
   assign rsp0_valid  = rsp0_valid_q;
   assign rsp0_result = rsp0_result_q;
   assign rsp0_flags  = rsp0_flags_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp1_result = rsp1_result_q;
   assign rsp1_flags  = rsp1_flags_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arb
//
// Directed testbench for alu_share_arb. A small behavioural ALU answers the
// registered alu_* outputs. FUNC codes: 000 AND, 001 OR, 010 XOR, 011 SLL,
// 100 SRL. The shift amount is b[2:0]. Carry is a + b carry-out for ADD and
// a borrow (a < b) for SUB.
// Honors ALU_ARB_FIXED_PRIO_EN for the tie-arbitration expectations.
// ---------------------------------------------------------------------------
module tb_alu_share_arb;

   localparam int DATA_W = 8;
`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit RR = 1'b0;
`else
   localparam bit RR = 1'b1;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req0_valid, req0_ready, req1_valid, req1_ready;
   logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]        req0_aluop, req1_aluop;
   logic [2:0]        req0_funct, req1_funct;
   logic              rsp0_valid, rsp1_valid;
   logic [DATA_W-1:0] rsp0_result, rsp1_result;
   logic [2:0]        rsp0_flags, rsp1_flags;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result;
   logic [1:0]        alu_aluop;
   logic [2:0]        alu_funct;
   logic              alu_zero, alu_negative, alu_carry;
   logic [8:0]        alu_t;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_share_arb #(.DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_aluop(req0_aluop), .req0_funct(req0_funct),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_aluop(req1_aluop), .req1_funct(req1_funct),
      .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
      .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_aluop(alu_aluop), .alu_funct(alu_funct),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
      .alu_carry(alu_carry)
   );

   // Behavioural ALU
   always_comb begin
      alu_t = 9'd0;
      case (alu_aluop)
         2'b00: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
         2'b01: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
         2'b10: begin
            case (alu_funct)
               3'd0:    alu_t = {1'b0, alu_a & alu_b};
               3'd1:    alu_t = {1'b0, alu_a | alu_b};
               3'd2:    alu_t = {1'b0, alu_a ^ alu_b};
               3'd3:    alu_t = {1'b0, alu_a << alu_b[2:0]};
               3'd4:    alu_t = {1'b0, alu_a >> alu_b[2:0]};
               default: alu_t = 9'd0;
            endcase
         end
         default: alu_t = {1'b0, alu_a};
      endcase
   end
   assign alu_result   = alu_t[7:0];
   assign alu_carry    = (alu_aluop[1] == 1'b0) ? alu_t[8] : 1'b0;
   assign alu_negative = alu_t[7];
   assign alu_zero     = (alu_t[7:0] == 8'h00);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int port, input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [2:0] fn);
      if (port == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_aluop = op; req0_funct = fn;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_aluop = op; req1_funct = fn;
      end
   endtask

   // One isolated request on a port, starting and ending in IDLE.
   task automatic run_single(input int port, input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] op, input logic [2:0] fn,
                             input logic [7:0] exp_r, input logic [2:0] exp_f);
      @(negedge clk);
      drive(port, 1'b1, a, b, op, fn);
      #1;
      chk("single_ready_win", (port == 0) ? req0_ready : req1_ready, 1);
      chk("single_ready_other", (port == 0) ? req1_ready : req0_ready, 0);
      @(posedge clk);
      #1;
      drive(port, 1'b0, a, b, op, fn);
      @(negedge clk);
      chk("exec_no_rsp", {rsp0_valid, rsp1_valid}, 0);
      chk("exec_alu_ops", {alu_a, alu_b, alu_aluop, alu_funct}, {a, b, op, fn});
      @(negedge clk);
      chk("rsp_valid", (port == 0) ? rsp0_valid : rsp1_valid, 1);
      chk("rsp_other_quiet", (port == 0) ? rsp1_valid : rsp0_valid, 0);
      chk("rsp_result", (port == 0) ? rsp0_result : rsp1_result, exp_r);
      chk("rsp_flags", (port == 0) ? rsp0_flags : rsp1_flags, exp_f);
      @(negedge clk);
      chk("rsp_one_cycle", {rsp0_valid, rsp1_valid}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic g, gn;
      rst_n = 1'b0;
      drive(0, 1'b0, 8'h00, 8'h00, 2'b00, 3'b000);
      drive(1, 1'b0, 8'h00, 8'h00, 2'b00, 3'b000);
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_ready", {req0_ready, req1_ready}, 0);
      chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
      chk("rst_rsp", {rsp0_result, rsp0_flags, rsp1_result, rsp1_flags}, 0);
      chk("rst_alu", {alu_a, alu_b, alu_aluop, alu_funct}, 0);
      rst_n = 1'b1;

      // Single ops
      run_single(0, 8'h7F, 8'h01, 2'b00, 3'b000, 8'h80, 3'b010);
      run_single(1, 8'h05, 8'h05, 2'b01, 3'b000, 8'h00, 3'b001);
      run_single(1, 8'h00, 8'h01, 2'b01, 3'b000, 8'hFF, 3'b110);

      // Continuous contention: req0 AND 0xF0&0x3C, req1 SLL 0x01<<3
      @(negedge clk);
      drive(0, 1'b1, 8'hF0, 8'h3C, 2'b10, 3'd0);
      drive(1, 1'b1, 8'h01, 8'h03, 2'b10, 3'd3);
      #1;
      g = 1'b0;
      chk("tie_first_rdy", {req0_ready, req1_ready}, 2'b10);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("tie_exec_rdy", {req0_ready, req1_ready}, 0);
         chk("tie_exec_rsp", {rsp0_valid, rsp1_valid}, 0);
         @(negedge clk);
         chk("tie_rsp_valid", {rsp0_valid, rsp1_valid}, g ? 2'b01 : 2'b10);
         chk("tie_rsp_result", g ? rsp1_result : rsp0_result, g ? 8'h08 : 8'h30);
         gn = RR ? ~g : 1'b0;
         chk("tie_next_rdy", {req0_ready, req1_ready}, gn ? 2'b01 : 2'b10);
         g = gn;
      end
      drive(0, 1'b0, 8'h00, 8'h00, 2'b00, 3'b000);
      drive(1, 1'b0, 8'h00, 8'h00, 2'b00, 3'b000);
      @(negedge clk);
      chk("tie_drain", {rsp0_valid, rsp1_valid}, 0);

      // Back-to-back on req0: 0x01+0x02, then 0x03+0x04 accepted in RESP
      @(negedge clk);
      drive(0, 1'b1, 8'h01, 8'h02, 2'b00, 3'b000);
      @(posedge clk);
      #1;
      drive(0, 1'b1, 8'h03, 8'h04, 2'b00, 3'b000);
      @(negedge clk);
      chk("b2b_exec_rdy", req0_ready, 0);
      @(negedge clk);
      chk("b2b_rsp1", {rsp0_valid, rsp0_result, rsp0_flags}, {1'b1, 8'h03, 3'b000});
      chk("b2b_rdy_in_resp", req0_ready, 1);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 8'h00, 8'h00, 2'b00, 3'b000);
      @(negedge clk);
      chk("b2b_gap", rsp0_valid, 0);
      @(negedge clk);
      chk("b2b_rsp2", {rsp0_valid, rsp0_result, rsp0_flags}, {1'b1, 8'h07, 3'b000});

      // Reset during EXEC of req1 PASS 0xAA
      @(negedge clk);
      drive(1, 1'b1, 8'hAA, 8'h00, 2'b11, 3'b000);
      #1;
      chk("pass_ready", req1_ready, 1);
      @(posedge clk);
      #1;
      drive(1, 1'b0, 8'h00, 8'h00, 2'b00, 3'b000);
      @(negedge clk);
      chk("pass_exec_alu", {alu_a, alu_aluop}, {8'hAA, 2'b11});
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp", {rsp0_valid, rsp1_valid, rsp0_result, rsp0_flags, rsp1_result, rsp1_flags}, 0);
      chk("midrst_alu", {alu_a, alu_b, alu_aluop, alu_funct}, 0);
      @(negedge clk);
      chk("midrst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
      rst_n = 1'b1;

      // Withdrawn tie after reset: req0 must be offered, nothing latched
      @(negedge clk);
      drive(0, 1'b1, 8'h55, 8'h11, 2'b01, 3'b000);
      drive(1, 1'b1, 8'h66, 8'h22, 2'b01, 3'b000);
      #1;
      chk("postrst_tie_rdy", {req0_ready, req1_ready}, 2'b10);
      drive(0, 1'b0, 8'h55, 8'h11, 2'b01, 3'b000);
      drive(1, 1'b0, 8'h66, 8'h22, 2'b01, 3'b000);
      @(negedge clk);
      chk("withdraw_no_latch", {alu_a, alu_b, alu_aluop}, 0);
      chk("withdraw_no_rsp", {rsp0_valid, rsp1_valid}, 0);

      // Normal service after reset: 0x10+0xF0 -> 0x00 with carry
      run_single(1, 8'h10, 8'hF0, 2'b00, 3'b000, 8'h00, 3'b101);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
